bus_master: RTL and testbench

//  Transmitting end of the valid/ready bus handshake: drives valid/data into a downstream

---
 rtl/bus_master.sv | 109 ++++++++++
 tb/tb_bus_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// Transmitting side of a valid/ready handshake: emits a burst of LEN beats with data = base + i,
// optionally separated by GAP idle cycles. Every output is driven straight from a flop.
`timescale 1ns/1ps

module bus_master #(
    parameter int DATA_W = 3,
    parameter int LEN_W  = 4,
    parameter int GAP    = 0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_GAP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             xfer;
    logic             last_beat;

    assign xfer      = valid_out && ready_in;
    assign last_beat = (beat_cnt + LEN_W'(1)) == len_q;

    // busy and done are registered alongside state so no output is a decode of the state bits.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            beat_cnt  <= '0;
            len_q     <= '0;
            gap_cnt   <= '0;
        end else begin
            // NOTE: done defaults low each cycle and is raised only on entry to DONE, giving a
            // single-cycle pulse without a separate clear path; non-blocking keeps the later
            // assignment in the same cycle the winner.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            state     <= SEND;
                            len_q     <= len;
                            valid_out <= 1'b1;
                            data_out  <= base;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) begin
                            state     <= DONE;
                            valid_out <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP == 0) begin
                            data_out <= data_out + DATA_W'(1);
                        end else begin
                            state     <= WAIT_GAP;
                            valid_out <= 1'b0;
                            gap_cnt   <= GAP_W'(GAP);
                        end
                    end
                end
                WAIT_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state     <= SEND;
                        valid_out <= 1'b1;
                        data_out  <= data_out + DATA_W'(1);
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: one GAP=0 instance and one GAP=2 instance, a negedge monitor that pops
// a scoreboard queue per accepted beat, and one task per scenario.
`timescale 1ns/1ps

module tb_bus_master;

    logic       sys_clk;
    logic       rst;
    logic       start0;
    logic       start2;
    logic [2:0] base;
    logic [3:0] len;
    logic       ready_in;

    logic       valid0, busy0, done0;
    logic [2:0] data0;
    logic [3:0] beat0;
    logic       valid2, busy2, done2;
    logic [2:0] data2;
    logic [3:0] beat2;

    int tests = 0;
    int fails = 0;

    logic [2:0] q0[$];
    logic [2:0] q2[$];

    bus_master #(.DATA_W(3), .LEN_W(4), .GAP(0)) dut0 (
        .sys_clk(sys_clk), .rst(rst), .start(start0), .base(base), .len(len),
        .ready_in(ready_in), .valid_out(valid0), .data_out(data0), .busy(busy0),
        .done(done0), .beat_cnt(beat0)
    );

    bus_master #(.DATA_W(3), .LEN_W(4), .GAP(2)) dut2 (
        .sys_clk(sys_clk), .rst(rst), .start(start2), .base(base), .len(len),
        .ready_in(ready_in), .valid_out(valid2), .data_out(data2), .busy(busy2),
        .done(done2), .beat_cnt(beat2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // Inputs change 2 ns after a rising edge and are stable at the falling edge, so a beat seen
    // with valid && ready at a negedge is exactly the beat that transfers on the next rising edge.
    initial begin : monitor
        bit         stall0 = 1'b0;
        bit         stall2 = 1'b0;
        bit         prev_rst = 1'b1;
        logic [2:0] held0 = '0;
        logic [2:0] held2 = '0;
        logic [2:0] exp_v;
        forever begin
            @(negedge sys_clk);
            if (stall0 && !prev_rst) begin
                tests++;
                if ({valid0, data0} !== {1'b1, held0}) begin
                    fails++;
                    $display("FAIL hold0: got valid=%b data=%0d expected valid=1 data=%0d", valid0, data0, held0);
                end
            end
            if (stall2 && !prev_rst) begin
                tests++;
                if ({valid2, data2} !== {1'b1, held2}) begin
                    fails++;
                    $display("FAIL hold2: got valid=%b data=%0d expected valid=1 data=%0d", valid2, data2, held2);
                end
            end
            if (valid0 && ready_in && !rst) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL beat0: got unexpected beat data=%0d, expected no beat", data0);
                end else begin
                    exp_v = q0.pop_front();
                    if (data0 !== exp_v) begin
                        fails++;
                        $display("FAIL beat0: got data=%0d expected %0d", data0, exp_v);
                    end
                end
            end
            if (valid2 && ready_in && !rst) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL beat2: got unexpected beat data=%0d, expected no beat", data2);
                end else begin
                    exp_v = q2.pop_front();
                    if (data2 !== exp_v) begin
                        fails++;
                        $display("FAIL beat2: got data=%0d expected %0d", data2, exp_v);
                    end
                end
            end
            stall0   = valid0 && !ready_in;
            stall2   = valid2 && !ready_in;
            held0    = data0;
            held2    = data2;
            prev_rst = rst;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    // Issues a one-cycle start to the selected instance and pushes the expected beats.
    // base/len are scrambled afterwards; the DUT must have latched them already.
    task automatic start_burst(input bit sel, input logic [2:0] b, input logic [3:0] l);
        base = b;
        len  = l;
        if (sel) start2 = 1'b1;
        else     start0 = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            if (sel) q2.push_back(b + 3'(i));
            else     q0.push_back(b + 3'(i));
        end
        step();
        start0 = 1'b0;
        start2 = 1'b0;
        base   = 3'($urandom);
        len    = 4'($urandom);
    endtask

    task automatic wait_done(input bit sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sys_clk);
            if (sel ? done2 : done0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge sys_clk);
        tests++;
        if ({valid0, data0, busy0, done0, beat0} !== 10'd0) begin
            fails++;
            $display("FAIL reset0: got %b expected %b", {valid0, data0, busy0, done0, beat0}, 10'd0);
        end
        tests++;
        if ({valid2, data2, busy2, done2, beat2} !== 10'd0) begin
            fails++;
            $display("FAIL reset2: got %b expected %b", {valid2, data2, busy2, done2, beat2}, 10'd0);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        ready_in = 1'b1;
        start_burst(1'b0, 3'd2, 4'd4);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] e;
            e = 3'd2 + 3'(i);
            @(negedge sys_clk);
            tests++;
            if ({valid0, data0, busy0} !== {1'b1, e, 1'b1}) begin
                fails++;
                $display("FAIL basic_beat%0d: got valid=%b data=%0d busy=%b expected 1/%0d/1", i, valid0, data0, busy0, e);
            end
        end
        @(negedge sys_clk);
        tests++;
        if ({done0, valid0, beat0} !== {1'b1, 1'b0, 4'd4}) begin
            fails++;
            $display("FAIL basic_done: got done=%b valid=%b beat_cnt=%0d expected 1/0/4", done0, valid0, beat0);
        end
        @(negedge sys_clk);
        tests++;
        if ({done0, busy0} !== 2'b00) begin
            fails++;
            $display("FAIL basic_idle: got done=%b busy=%b expected 0/0", done0, busy0);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        ready_in = 1'b1;
        start_burst(1'b0, 3'd6, 4'd3);
        step();
        ready_in = 1'b0;
        start0   = 1'b1;
        base     = 3'd3;
        len      = 4'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            tests++;
            if ({valid0, data0} !== {1'b1, 3'd7}) begin
                fails++;
                $display("FAIL stall%0d: got valid=%b data=%0d expected 1/7", k, valid0, data0);
            end
            step();
            start0 = 1'b0;
        end
        ready_in = 1'b1;
        wait_done(1'b0, 20, ok);
        tests++;
        if (!ok || beat0 !== 4'd3) begin
            fails++;
            $display("FAIL bp_done: got done_seen=%b beat_cnt=%0d expected 1/3", ok, beat0);
        end
        step();
    endtask

    task automatic test_gap();
        logic [6:0] pat;
        ready_in = 1'b1;
        start_burst(1'b1, 3'd0, 4'd3);
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            pat[6-i] = valid2;
        end
        tests++;
        if (pat !== 7'b1001001) begin
            fails++;
            $display("FAIL gap_pattern: got %b expected %b", pat, 7'b1001001);
        end
        @(negedge sys_clk);
        tests++;
        if ({done2, beat2} !== {1'b1, 4'd3}) begin
            fails++;
            $display("FAIL gap_done: got done=%b beat_cnt=%0d expected 1/3", done2, beat2);
        end
        step();
    endtask

    task automatic test_len_zero();
        ready_in = 1'b0;
        start_burst(1'b0, 3'd5, 4'd0);
        start0 = 1'b1;
        base   = 3'd1;
        len    = 4'd5;
        @(negedge sys_clk);
        tests++;
        if ({done0, busy0, valid0, beat0} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL len0_done: got done=%b busy=%b valid=%b beat=%0d expected 1/1/0/0", done0, busy0, valid0, beat0);
        end
        step();
        start0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge sys_clk);
            tests++;
            if ({done0, busy0, valid0} !== 3'b000) begin
                fails++;
                $display("FAIL len0_after%0d: got done=%b busy=%b valid=%b expected 0/0/0", k, done0, busy0, valid0);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit saw;
        ready_in = 1'b1;
        start_burst(1'b0, 3'd1, 4'd6);
        step();
        step();
        tests++;
        if (beat0 !== 4'd2) begin
            fails++;
            $display("FAIL mid_pre: got beat_cnt=%0d expected 2", beat0);
        end
        ready_in = 1'b0;
        rst      = 1'b1;
        start0   = 1'b1;
        step();
        rst    = 1'b0;
        start0 = 1'b0;
        @(negedge sys_clk);
        tests++;
        if ({valid0, busy0, done0, beat0, data0} !== 10'd0) begin
            fails++;
            $display("FAIL mid_reset: got %b expected %b", {valid0, busy0, done0, beat0, data0}, 10'd0);
        end
        tests++;
        if (q0.size() != 4) begin
            fails++;
            $display("FAIL mid_leftover: got %0d pending beats expected 4", q0.size());
        end
        q0.delete();
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            if (done0 || busy0) saw = 1'b1;
        end
        tests++;
        if (saw !== 1'b0) begin
            fails++;
            $display("FAIL mid_nodone: got done/busy activity=%b expected 0", saw);
        end
        step();
    endtask

    task automatic test_random();
        for (int b = 0; b < 20; b++) begin
            bit         ok;
            logic [3:0] l;
            l = 4'($urandom_range(1, 15));
            ready_in = ($urandom_range(0, 99) < 60);
            start_burst(1'b0, 3'($urandom), l);
            ok = 1'b0;
            for (int c = 0; c < 400 && !ok; c++) begin
                ready_in = ($urandom_range(0, 99) < 60);
                @(negedge sys_clk);
                if (done0) ok = 1'b1;
                else       step();
            end
            tests++;
            if (!ok || beat0 !== l) begin
                fails++;
                $display("FAIL rand%0d_done: got done_seen=%b beat_cnt=%0d expected 1/%0d", b, ok, beat0, l);
            end
            tests++;
            if (q0.size() != 0) begin
                fails++;
                $display("FAIL rand%0d_drain: got %0d beats outstanding expected 0", b, q0.size());
            end
            q0.delete();
            step();
        end
        ready_in = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start0   = 1'b0;
        start2   = 1'b0;
        base     = '0;
        len      = '0;
        ready_in = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_len_zero();
        test_reset_mid();
        test_random();
        step();
        tests++;
        if (q0.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL final_queues: got q0=%0d q2=%0d expected 0/0", q0.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
